// File: rtl/fb_rect_fill_ctrl.sv
// Rectangle-fill / clear-screen sequencer feeding a framebuffer pixel write port.
// Clips each command to the visible area and writes one pixel per clock in raster order.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// FILL   | writing one pixel per cycle inside the latched clipped bounds
// DONE   | one-cycle completion pulse (normal end, abort or empty command)
module fb_rect_fill_ctrl #(
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clear,
    input  logic [10:0] cmd_x0,
    input  logic [10:0] cmd_x1,
    input  logic [10:0] cmd_y0,
    input  logic [10:0] cmd_y1,
    input  logic [7:0]  cmd_r,
    input  logic [7:0]  cmd_g,
    input  logic [7:0]  cmd_b,
    input  logic        abort,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        pixel_write,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [10:0] XLAST = 11'(XMAX - 1);
    localparam logic [10:0] YLAST = 11'(YMAX - 1);
    localparam logic [10:0] XLIM  = 11'(XMAX);
    localparam logic [10:0] YLIM  = 11'(YMAX);

    logic [1:0]  state;
    logic [10:0] x0_q, xe_q, ye_q;
    logic [10:0] cx0, cy0, cxe, cye;
    logic        empty;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;

    // Clipped bounds of the presented command; only used on accept.
    always_comb begin
        cx0   = 11'd0;
        cy0   = 11'd0;
        cxe   = XLAST;
        cye   = YLAST;
        empty = 1'b0;
        if (!cmd_clear) begin
            cx0   = cmd_x0;
            cy0   = cmd_y0;
            cxe   = (cmd_x1 > XLAST) ? XLAST : cmd_x1;
            cye   = (cmd_y1 > YLAST) ? YLAST : cmd_y1;
            empty = (cmd_x0 > cxe) || (cmd_y0 > cye) ||
                    (cmd_x0 >= XLIM) || (cmd_y0 >= YLIM);
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            x0_q        <= 11'd0;
            xe_q        <= 11'd0;
            ye_q        <= 11'd0;
            x           <= 11'd0;
            y           <= 11'd0;
            r           <= 8'd0;
            g           <= 8'd0;
            b           <= 8'd0;
            pixel_write <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pixel_write <= 1'b0;
                    done        <= 1'b0;
                    if (cmd_valid) begin
                        r    <= cmd_r;
                        g    <= cmd_g;
                        b    <= cmd_b;
                        x0_q <= cx0;
                        xe_q <= cxe;
                        ye_q <= cye;
                        if (empty) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_FILL;
                            x           <= cx0;
                            y           <= cy0;
                            pixel_write <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    // Last pixel and abort share the same exit, so both give one done pulse.
                    if (abort || (x == xe_q && y == ye_q)) begin
                        state       <= S_DONE;
                        pixel_write <= 1'b0;
                        done        <= 1'b1;
                    end else if (x != xe_q) begin
                        x <= x + 11'd1;
                    end else begin
                        x <= x0_q;
                        y <= y + 11'd1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    pixel_write <= 1'b0;
                    done        <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    pixel_write <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill_ctrl.sv
// Directed self-checking bench for fb_rect_fill_ctrl; a second small-screen instance
// exercises a complete clear-screen pass in a short run.
module tb_fb_rect_fill_ctrl;

    logic        clk50 = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_clear, abort;
    logic [10:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic [7:0]  cmd_r, cmd_g, cmd_b;
    logic        cmd_ready, pixel_write, busy, done;
    logic [10:0] x, y;
    logic [7:0]  r, g, b;

    logic        s_cmd_valid;
    logic        s_cmd_ready, s_pixel_write, s_busy, s_done;
    logic [10:0] s_x, s_y;
    logic [7:0]  s_r, s_g, s_b;

    int passed = 0;
    int total  = 0;

    always #10 clk50 = ~clk50;

    fb_rect_fill_ctrl #(.XMAX(640), .YMAX(480)) dut (
        .clk50(clk50), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .abort(abort),
        .x(x), .y(y), .r(r), .g(g), .b(b),
        .pixel_write(pixel_write), .busy(busy), .done(done)
    );

    fb_rect_fill_ctrl #(.XMAX(32), .YMAX(24)) dut_s (
        .clk50(clk50), .reset_n(reset_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_clear(1'b1),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_r(8'h12), .cmd_g(8'h34), .cmd_b(8'h56), .abort(1'b0),
        .x(s_x), .y(s_y), .r(s_r), .g(s_g), .b(s_b),
        .pixel_write(s_pixel_write), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    // Leaves the bench in cycle T+1 after the accepting edge T.
    task automatic issue(input logic clr, input logic [10:0] a0, input logic [10:0] a1,
                         input logic [10:0] b0, input logic [10:0] b1,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_clear = clr;
        cmd_x0 = a0; cmd_x1 = a1; cmd_y0 = b0; cmd_y1 = b1;
        cmd_r = rr; cmd_g = gg; cmd_b = bb;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cnt, seq_err, n;
        logic [10:0] ex, ey, lx, ly;
        logic seen_done;

        reset_n = 1'b0;
        cmd_valid = 0; cmd_clear = 0; abort = 0; s_cmd_valid = 0;
        cmd_x0 = 0; cmd_x1 = 0; cmd_y0 = 0; cmd_y1 = 0;
        cmd_r = 0; cmd_g = 0; cmd_b = 0;
        tick();
        chk("rst_pw", pixel_write, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_xy", {x, y}, 0);
        @(negedge clk50);
        reset_n = 1'b1;
        tick();

        // Small fill 10..12 x 5..6
        issue(0, 11'd10, 11'd12, 11'd5, 11'd6, 8'hFF, 8'h00, 8'h80);
        chk("small_rgb", {r, g, b}, 24'hFF0080);
        for (int i = 0; i < 6; i++) begin
            chk("small_pw", pixel_write, 1);
            chk("small_x", x, 10 + (i % 3));
            chk("small_y", y, 5 + (i / 3));
            chk("small_busy", busy, 1);
            tick();
        end
        chk("small_end_pw", pixel_write, 0);
        chk("small_done", done, 1);
        chk("small_ready_lo", cmd_ready, 0);
        tick();
        chk("small_ready_hi", cmd_ready, 1);
        chk("small_done_lo", done, 0);

        // Clipping at the bottom-right corner
        issue(0, 11'd638, 11'd700, 11'd479, 11'd900, 8'h11, 8'h22, 8'h33);
        chk("clip_p0", {pixel_write, x, y}, {1'b1, 11'd638, 11'd479});
        tick();
        chk("clip_p1", {pixel_write, x, y}, {1'b1, 11'd639, 11'd479});
        tick();
        chk("clip_done", {pixel_write, done}, 2'b01);
        tick();
        chk("clip_ready", cmd_ready, 1);

        // Empty commands
        issue(0, 11'd20, 11'd10, 11'd0, 11'd5, 8'h01, 8'h02, 8'h03);
        chk("empty_a", {pixel_write, done, cmd_ready}, 3'b010);
        tick();
        chk("empty_a_ready", {pixel_write, done, cmd_ready}, 3'b001);
        issue(0, 11'd640, 11'd650, 11'd0, 11'd0, 8'h01, 8'h02, 8'h03);
        chk("empty_b", {pixel_write, done, cmd_ready}, 3'b010);
        tick();
        chk("empty_b_ready", {pixel_write, done, cmd_ready}, 3'b001);

        // Abort on the 4th write, with a command held pending while busy
        issue(0, 11'd0, 11'd9, 11'd0, 11'd9, 8'hAA, 8'hBB, 8'hCC);
        cmd_x0 = 11'd1; cmd_x1 = 11'd1; cmd_y0 = 11'd1; cmd_y1 = 11'd1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_w", {pixel_write, x, y}, {1'b1, 11'(i), 11'd0});
            chk("abort_ready_lo", cmd_ready, 0);
            if (i == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("abort_done", {pixel_write, done, cmd_ready}, 3'b010);
        tick();
        chk("abort_idle", {pixel_write, done, cmd_ready}, 3'b001);
        tick();
        cmd_valid = 1'b0;
        chk("held_cmd_w", {pixel_write, x, y}, {1'b1, 11'd1, 11'd1});
        tick();
        chk("held_cmd_done", {pixel_write, done}, 2'b01);
        tick();

        // Abort coinciding with the last pixel
        issue(0, 11'd3, 11'd4, 11'd7, 11'd7, 8'h01, 8'h01, 8'h01);
        tick();
        chk("ablast_w2", {pixel_write, x, y}, {1'b1, 11'd4, 11'd7});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ablast_done", {pixel_write, done}, 2'b01);
        tick();
        chk("ablast_once", {done, cmd_ready}, 2'b01);

        // Full-size clear: check raster wrap at column 639, then abort
        issue(1, 11'd5, 11'd6, 11'd5, 11'd6, 8'h00, 8'h00, 8'h00);
        ex = 0; ey = 0; seq_err = 0;
        for (int i = 0; i < 700; i++) begin
            if (!pixel_write || x != ex || y != ey) seq_err++;
            if (i == 639) chk("clr_row_end", {x, y}, {11'd639, 11'd0});
            if (i == 640) chk("clr_row_wrap", {x, y}, {11'd0, 11'd1});
            if (ex == 11'd639) begin ex = 0; ey = ey + 11'd1; end
            else ex = ex + 11'd1;
            if (i == 699) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("clr_seq_err", seq_err, 0);
        chk("clr_rgb", {r, g, b}, 24'h000000);
        chk("clr_abort_done", {pixel_write, done}, 2'b01);
        tick();

        // Complete clear on the 32x24 instance
        s_cmd_valid = 1'b1;
        tick();
        s_cmd_valid = 1'b0;
        cnt = 0; n = 0; seen_done = 0; lx = 0; ly = 0;
        while (!seen_done && n < 2000) begin
            if (s_pixel_write) begin cnt++; lx = s_x; ly = s_y; end
            if (s_done) seen_done = 1;
            tick();
            n++;
        end
        chk("sclr_done_seen", seen_done, 1);
        chk("sclr_count", cnt, 768);
        chk("sclr_last", {lx, ly}, {11'd31, 11'd23});
        chk("sclr_rgb", {s_r, s_g, s_b}, 24'h123456);
        chk("sclr_ready", s_cmd_ready, 1);

        // Reset mid-fill drops the fill without a done pulse
        issue(0, 11'd0, 11'd9, 11'd0, 11'd9, 8'h55, 8'h55, 8'h55);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_ready_now", cmd_ready, 1);
        tick();
        chk("midrst_out", {pixel_write, done, cmd_ready, x, y}, {3'b001, 22'd0});
        @(negedge clk50);
        reset_n = 1'b1;
        tick();
        chk("midrst_no_done", done, 0);
        issue(0, 11'd2, 11'd2, 11'd3, 11'd3, 8'h09, 8'h08, 8'h07);
        chk("post_rst_w", {pixel_write, x, y, r, g, b}, {1'b1, 11'd2, 11'd3, 24'h090807});
        tick();
        chk("post_rst_done", {pixel_write, done}, 2'b01);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill_ctrl.md
Name: fb_rect_fill_ctrl

Overview:
Drawing sequencer placed in front of the 640x480 colour framebuffer's pixel write port (x, y, r, g, b, pixel_write).
- Accepts one rectangle-fill or clear-screen command at a time over a valid/ready handshake.
- Clips the command to the visible area, then issues one pixel write per clock in raster order.
- Pulses done on completion or abort.

Parameters:
XMAX, 640, visible width in pixels; x coordinates range 0..XMAX-1
YMAX, 480, visible height in pixels; y coordinates range 0..YMAX-1

Ports:
clk50  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_clear  input  1  1 = fill the whole screen; cmd_x0/y0/x1/y1 are ignored
cmd_x0, cmd_x1  input  11  inclusive left and right column
cmd_y0, cmd_y1  input  11  inclusive top and bottom row
cmd_r, cmd_g, cmd_b  input  8 each  fill colour
abort  input  1  stop the current fill
x, y  output  11 each  pixel coordinate to the framebuffer
r, g, b  output  8 each  pixel colour to the framebuffer
pixel_write  output  1  write strobe, one pixel per cycle
busy  output  1  high in FILL and DONE
done  output  1  one-cycle completion pulse

Behaviour:
- States are IDLE, FILL and DONE.
- cmd_ready = (state == IDLE), decoded combinationally. busy = ~cmd_ready.
- All other outputs are registered.
- Reset (reset_n low, async):
  - state returns to IDLE.
  - x, y, r, g, b, pixel_write and done go to 0.
  - cmd_ready is 1 immediately.
  - A fill in progress is dropped with no done pulse.
- Accept (IDLE, cmd_valid high at edge T):
  - Latch the colour and the clipped bounds.
  - Clear command: bounds are 0..XMAX-1 and 0..YMAX-1.
  - Otherwise clipping is xe = min(cmd_x1, XMAX-1) and ye = min(cmd_y1, YMAX-1).
  - Empty command: cmd_x0 > xe, or cmd_y0 > ye, or cmd_x0 >= XMAX, or cmd_y0 >= YMAX. Go to DONE with no writes; done is high in cycle T+1.
  - Non-empty command: go to FILL. In cycle T+1, x = x0, y = y0 and pixel_write = 1.
- FILL, one pixel per cycle, no stalls:
  - If x != xe: x increments.
  - If x == xe and y != ye: x returns to x0 and y increments.
  - If x == xe and y == ye: go to DONE.
  - A command of N = (xe-x0+1)*(ye-y0+1) pixels drives pixel_write high for exactly cycles T+1..T+N.
  - r, g, b hold the latched colour throughout the fill.
- DONE: lasts one cycle. pixel_write = 0 and done = 1, then go to IDLE. cmd_ready rises in cycle T+N+2.
- Idle outputs: x, y, r, g, b hold their last values; pixel_write and done are 0.
- abort:
  - Sampled only in FILL. If abort is high at an edge, the pixel of that cycle was already written.
  - Next cycle: pixel_write = 0, state goes to DONE and done pulses.
  - abort is ignored in IDLE and DONE.
  - If abort coincides with the last pixel, behaviour is identical to normal completion: one done pulse.
- Input rules: cmd_valid and the command fields are ignored when cmd_ready = 0, so no command is queued while busy.
- Arithmetic: coordinates are 11-bit unsigned and counters never wrap. Comparisons use the clipped bounds, so x and y always stay below XMAX and YMAX.

Test Plan:
- Reset values: reset_n low mid-stream -> next edge gives pixel_write=0, done=0, cmd_ready=1, x=y=0. After release, a new command is accepted normally.
- Small fill: x0=10, x1=12, y0=5, y1=6, colour FF/00/80 -> 6 writes on consecutive cycles in order (10,5)(11,5)(12,5)(10,6)(11,6)(12,6). done is high in cycle 7 after accept; cmd_ready=1 in cycle 8.
- Clipping: x0=638, x1=700, y0=479, y1=900 -> exactly 2 writes, (638,479) and (639,479), then done.
- Empty command: x0=20, x1=10 -> no pixel_write; done in the cycle after accept. Separately, x0=640 -> also empty.
- Clear: cmd_clear=1 with colour 00/00/00 -> 307200 writes; the last one is at (639,479); done follows. A bench counter of pixel_write pulses must equal 307200.
- Abort: fill 0..9 x 0..9, assert abort on the 4th write cycle -> exactly 4 writes, then done on the next cycle. A cmd_valid held high during the busy period is not accepted until cmd_ready returns.
